// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_pkg
//  Brief    : Shared types and helpers for the multi-source interrupt
//             controller: FSM state type, source limits, mcause builder.
//  Revision : 1.0 - initial release
// ============================================================================
package irq_pkg;

    // Architectural ceiling on request lines (width of the mie CSR).
    localparam int MAX_SRC       = 32;
    // mcause bit that flags an interrupt (as opposed to an exception).
    localparam int CAUSE_INT_BIT = 31;

    // Handshake phases towards the core.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FINISH = 2'd2
    } irq_state_e;

    // mcause = {interrupt flag, offset + source id}.
    function automatic logic [31:0] build_mcause(input logic [4:0]  id,
                                                 input logic [30:0] offset);
        logic [31:0] w_cause;
        w_cause                = '0;
        w_cause[CAUSE_INT_BIT] = 1'b1;
        w_cause[30:0]          = offset + 31'(id);
        return w_cause;
    endfunction

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : irq_prio_enc
//  Brief    : Combinational lowest-index-first priority encoder. valid is
//             high when any request bit is set; idx is the lowest set index.
//  Revision : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
    parameter  int WIDTH   = 16,
    localparam int c_idx_w = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]   req,
    output logic               valid,
    output logic [c_idx_w-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = c_idx_w'(i);
            end
        end
    end

endmodule : irq_prio_enc
`default_nettype wire

// File: rtl/irq_ctrl_multi.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl_multi
//  Brief    : NUM_SRC-line interrupt controller. Edge or level request per
//             line, masked by mie, lowest index wins, single outstanding
//             service handshaked with the core via INT/mcause/INT_RST.
//             Returns a one-hot completion pulse and sticky overrun flags.
//  Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl_multi
    import irq_pkg::*;
#(
    parameter int                 NUM_SRC      = 16,
    parameter logic [NUM_SRC-1:0] EDGE_MASK    = {NUM_SRC{1'b1}},
    parameter int                 CAUSE_OFFSET = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_SRC-1:0] int_req_i,
    input  logic [31:0]        mie_i,
    input  logic               INT_RST_i,
    output logic               INT_o,
    output logic [31:0]        mcause_o,
    output logic [NUM_SRC-1:0] int_fin_o,
    output logic [NUM_SRC-1:0] pending_o,
    output logic [NUM_SRC-1:0] overrun_o
);

    localparam int c_id_w = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] r_req_q;
    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] r_ovr;
    logic [NUM_SRC-1:0] r_fin;
    logic [c_id_w-1:0]  r_id;
    logic               r_int;
    logic [31:0]        r_mcause;
    irq_state_e         r_state;

    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_pend;
    logic [NUM_SRC-1:0] w_elig;
    logic               w_done;
    logic               w_valid;
    logic [c_id_w-1:0]  w_idx;

    // Only edge-latched lines produce edge events.
    assign w_edge = int_req_i & ~r_req_q & EDGE_MASK;

    // Completion of the captured id happens on the strobe while ACTIVE.
    assign w_done = (r_state == ACTIVE) && INT_RST_i;
    assign w_clr  = w_done ? (NUM_SRC'(1) << r_id) : '0;

    // Edge lines come from the latch, level lines straight from the request.
    assign w_pend = (r_pend & EDGE_MASK) | (int_req_i & ~EDGE_MASK);
    assign w_elig = w_pend & mie_i[NUM_SRC-1:0] & ~w_clr;

    irq_prio_enc #(
        .WIDTH (NUM_SRC)
    ) u_prio_enc (
        .req   (w_elig),
        .valid (w_valid),
        .idx   (w_idx)
    );

    // mie bits above the populated sources carry no meaning here.
    generate
        if (NUM_SRC < MAX_SRC) begin : g_mie_unused
            logic w_unused_mie;
            assign w_unused_mie = ^mie_i[MAX_SRC-1:NUM_SRC];
        end
    endgenerate

    // Edge detector, pending latch and overrun flags; a new edge beats a clear.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_req_q <= '0;
            r_pend  <= '0;
            r_ovr   <= '0;
        end else begin
            r_req_q <= int_req_i;
            r_pend  <= ((r_pend & ~w_clr) | w_edge) & EDGE_MASK;
            r_ovr   <= (r_ovr & ~w_clr) | (w_edge & r_pend);
        end
    end

    // Service handshake: capture in IDLE, hold in ACTIVE, pulse fin in FINISH.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state  <= IDLE;
            r_int    <= 1'b0;
            r_mcause <= '0;
            r_fin    <= '0;
            r_id     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_fin <= '0;
                    if (w_valid) begin
                        r_id     <= w_idx;
                        r_mcause <= build_mcause(5'(w_idx), 31'(CAUSE_OFFSET));
                        r_int    <= 1'b1;
                        r_state  <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (INT_RST_i) begin
                        r_int   <= 1'b0;
                        r_fin   <= w_clr;
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    r_fin   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_int   <= 1'b0;
                    r_fin   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign INT_o     = r_int;
    assign mcause_o  = r_mcause;
    assign int_fin_o = r_fin;
    assign pending_o = w_pend;
    assign overrun_o = r_ovr;

endmodule : irq_ctrl_multi
`default_nettype wire

// File: tb/tb_irq_ctrl_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_ctrl_multi
//  Brief    : Self-checking bench for irq_ctrl_multi (16 sources, source 0
//             level-sensitive, cause offset 16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl_multi;

    localparam logic [15:0] c_em = 16'hFFFE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] int_req;
    logic [31:0] mie;
    logic        int_rst;
    logic        w_int;
    logic [31:0] w_mcause;
    logic [15:0] w_fin;
    logic [15:0] w_pend;
    logic [15:0] w_ovr;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    irq_ctrl_multi #(
        .NUM_SRC      (16),
        .EDGE_MASK    (c_em),
        .CAUSE_OFFSET (16)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .int_req_i (int_req),
        .mie_i     (mie),
        .INT_RST_i (int_rst),
        .INT_o     (w_int),
        .mcause_o  (w_mcause),
        .int_fin_o (w_fin),
        .pending_o (w_pend),
        .overrun_o (w_ovr)
    );

    typedef struct {
        logic        rn;
        logic [15:0] req;
        logic [31:0] mie;
        logic        irst;
        logic        e_int;
        logic [31:0] e_cause;
        logic [15:0] e_fin;
        logic [15:0] e_pend;
        logic [15:0] e_ovr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic drive(input logic rn, input logic [15:0] req, input logic [31:0] m,
                         input logic irst);
        rst_n   = rn;
        int_req = req;
        mie     = m;
        int_rst = irst;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic e_int, input logic [31:0] e_cause,
                             input logic [15:0] e_fin, input logic [15:0] e_pend,
                             input logic [15:0] e_ovr);
        chk({tag, " INT"},     {31'b0, w_int}, {31'b0, e_int});
        chk({tag, " mcause"},  w_mcause,       e_cause);
        chk({tag, " int_fin"}, {16'b0, w_fin}, {16'b0, e_fin});
        chk({tag, " pending"}, {16'b0, w_pend}, {16'b0, e_pend});
        chk({tag, " overrun"}, {16'b0, w_ovr}, {16'b0, e_ovr});
    endtask

    task automatic step(input string tag, input logic rn, input logic [15:0] req,
                        input logic [31:0] m, input logic irst, input logic e_int,
                        input logic [31:0] e_cause, input logic [15:0] e_fin,
                        input logic [15:0] e_pend, input logic [15:0] e_ovr);
        drive(rn, req, m, irst);
        check_all(tag, e_int, e_cause, e_fin, e_pend, e_ovr);
    endtask

    task automatic add(input logic rn, input logic [15:0] req, input logic [31:0] m,
                       input logic irst, input logic e_int, input logic [31:0] e_cause,
                       input logic [15:0] e_fin, input logic [15:0] e_pend,
                       input logic [15:0] e_ovr);
        vec_t v;
        v.rn = rn; v.req = req; v.mie = m; v.irst = irst; v.e_int = e_int;
        v.e_cause = e_cause; v.e_fin = e_fin; v.e_pend = e_pend; v.e_ovr = e_ovr;
        tbl.push_back(v);
    endtask

    // Reference model: one outstanding service, pending bits per source.
    logic [15:0] m_prev, m_pend, m_ovr, m_fin;
    logic [31:0] m_cause;
    int          m_srv;

    task automatic model_step(input logic rn, input logic [15:0] req, input logic [31:0] m,
                              input logic irst);
        logic [15:0] edges, pend_now, n_pend, n_ovr, n_fin;
        int          n_srv;
        bit          found;
        if (!rn) begin
            m_prev = '0; m_pend = '0; m_ovr = '0; m_fin = '0; m_cause = '0; m_srv = -1;
            return;
        end
        edges    = req & ~m_prev & c_em;
        pend_now = m_pend | (req & ~c_em);
        n_pend   = m_pend;
        n_ovr    = m_ovr;
        n_fin    = '0;
        n_srv    = m_srv;
        if (m_srv >= 0 && irst) begin
            n_pend[m_srv] = 1'b0;
            n_ovr[m_srv]  = 1'b0;
            n_fin[m_srv]  = 1'b1;
            n_srv         = -1;
        end
        for (int i = 0; i < 16; i++) begin
            if (edges[i]) begin
                if (m_pend[i]) n_ovr[i] = 1'b1;
                n_pend[i] = 1'b1;
            end
        end
        if (m_srv < 0 && m_fin == 16'h0) begin
            found = 1'b0;
            for (int i = 0; i < 16; i++) begin
                if (!found && pend_now[i] && m[i]) begin
                    found   = 1'b1;
                    n_srv   = i;
                    m_cause = 32'h8000_0000 + 32'(16 + i);
                end
            end
        end
        m_pend = n_pend;
        m_ovr  = n_ovr;
        m_fin  = n_fin;
        m_srv  = n_srv;
        m_prev = req;
    endtask

    initial begin
        rst_n = 1'b0; int_req = '0; mie = '0; int_rst = 1'b0;

        // rn  req      mie       rst  INT  mcause        fin      pend     ovr
        add(0, 16'h0000, 32'h0000, 0,  0, 32'h0,         16'h0,  16'h0,  16'h0); // reset
        add(1, 16'h0008, 32'h0008, 0,  0, 32'h0,         16'h0,  16'h8,  16'h0); // pulse src3
        add(1, 16'h0000, 32'h0008, 0,  1, 32'h8000_0013, 16'h0,  16'h8,  16'h0);
        add(1, 16'h0000, 32'h0008, 1,  0, 32'h8000_0013, 16'h8,  16'h0,  16'h0);
        add(1, 16'h0000, 32'h0008, 0,  0, 32'h8000_0013, 16'h0,  16'h0,  16'h0);
        add(1, 16'h0024, 32'hFFFF, 0,  0, 32'h8000_0013, 16'h0,  16'h24, 16'h0); // src5+src2
        add(1, 16'h0000, 32'hFFFF, 0,  1, 32'h8000_0012, 16'h0,  16'h24, 16'h0);
        add(1, 16'h0000, 32'hFFFF, 0,  1, 32'h8000_0012, 16'h0,  16'h24, 16'h0);
        add(1, 16'h0000, 32'hFFFF, 1,  0, 32'h8000_0012, 16'h4,  16'h20, 16'h0);
        add(1, 16'h0000, 32'hFFFF, 0,  0, 32'h8000_0012, 16'h0,  16'h20, 16'h0);
        add(1, 16'h0000, 32'hFFFF, 0,  1, 32'h8000_0015, 16'h0,  16'h20, 16'h0);
        add(1, 16'h0000, 32'hFFFF, 1,  0, 32'h8000_0015, 16'h20, 16'h0,  16'h0);
        add(1, 16'h0000, 32'hFFFF, 0,  0, 32'h8000_0015, 16'h0,  16'h0,  16'h0);
        add(1, 16'h0080, 32'h0000, 0,  0, 32'h8000_0015, 16'h0,  16'h80, 16'h0); // masked src7
        add(1, 16'h0000, 32'h0000, 0,  0, 32'h8000_0015, 16'h0,  16'h80, 16'h0);
        add(1, 16'h0000, 32'h0080, 0,  1, 32'h8000_0017, 16'h0,  16'h80, 16'h0);
        add(1, 16'h0000, 32'h0080, 1,  0, 32'h8000_0017, 16'h80, 16'h0,  16'h0);
        add(1, 16'h0000, 32'h0080, 0,  0, 32'h8000_0017, 16'h0,  16'h0,  16'h0);
        add(1, 16'h0002, 32'h0000, 0,  0, 32'h8000_0017, 16'h0,  16'h2,  16'h0); // overrun src1
        add(1, 16'h0000, 32'h0000, 0,  0, 32'h8000_0017, 16'h0,  16'h2,  16'h0);
        add(1, 16'h0002, 32'h0000, 0,  0, 32'h8000_0017, 16'h0,  16'h2,  16'h2);
        add(1, 16'h0000, 32'h0002, 0,  1, 32'h8000_0011, 16'h0,  16'h2,  16'h2);
        add(1, 16'h0000, 32'h0002, 1,  0, 32'h8000_0011, 16'h2,  16'h0,  16'h0);
        add(1, 16'h0000, 32'h0002, 0,  0, 32'h8000_0011, 16'h0,  16'h0,  16'h0);
        add(1, 16'h0000, 32'h0002, 0,  0, 32'h8000_0011, 16'h0,  16'h0,  16'h0);

        @(negedge clk);
        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].rn, tbl[r].req, tbl[r].mie, tbl[r].irst);
            check_all($sformatf("row%0d", r), tbl[r].e_int, tbl[r].e_cause,
                      tbl[r].e_fin, tbl[r].e_pend, tbl[r].e_ovr);
        end

        // Level source 0 held through the first completion: serviced twice.
        step("lvl1",  1, 16'h1, 32'h1, 0, 1, 32'h8000_0010, 16'h0, 16'h1, 16'h0);
        step("lvl2",  1, 16'h1, 32'h1, 1, 0, 32'h8000_0010, 16'h1, 16'h1, 16'h0);
        step("lvl3",  1, 16'h1, 32'h1, 0, 0, 32'h8000_0010, 16'h0, 16'h1, 16'h0);
        step("lvl4",  1, 16'h1, 32'h1, 0, 1, 32'h8000_0010, 16'h0, 16'h1, 16'h0);
        step("lvl5",  1, 16'h1, 32'h1, 1, 0, 32'h8000_0010, 16'h1, 16'h1, 16'h0);
        step("lvl6",  1, 16'h0, 32'h1, 0, 0, 32'h8000_0010, 16'h0, 16'h0, 16'h0);
        step("lvl7",  1, 16'h0, 32'h1, 0, 0, 32'h8000_0010, 16'h0, 16'h0, 16'h0);
        // Level source dropped right after its pulse: serviced once.
        step("lvl8",  1, 16'h1, 32'h1, 0, 1, 32'h8000_0010, 16'h0, 16'h1, 16'h0);
        step("lvl9",  1, 16'h1, 32'h1, 1, 0, 32'h8000_0010, 16'h1, 16'h1, 16'h0);
        step("lvl10", 1, 16'h0, 32'h1, 0, 0, 32'h8000_0010, 16'h0, 16'h0, 16'h0);
        step("lvl11", 1, 16'h0, 32'h1, 0, 0, 32'h8000_0010, 16'h0, 16'h0, 16'h0);

        // Reset while ACTIVE abandons the service; later strobe is ignored.
        step("rst1", 1, 16'h10, 32'hFFFF, 0, 0, 32'h8000_0010, 16'h0, 16'h10, 16'h0);
        step("rst2", 1, 16'h00, 32'hFFFF, 0, 1, 32'h8000_0014, 16'h0, 16'h10, 16'h0);
        step("rst3", 0, 16'h00, 32'hFFFF, 0, 0, 32'h0,         16'h0, 16'h0,  16'h0);
        step("rst4", 1, 16'h00, 32'hFFFF, 1, 0, 32'h0,         16'h0, 16'h0,  16'h0);
        step("rst5", 1, 16'h00, 32'hFFFF, 0, 0, 32'h0,         16'h0, 16'h0,  16'h0);

        // New edge on the id being completed: set wins, overrun flagged.
        step("sw1", 1, 16'h40, 32'h40, 0, 0, 32'h0,         16'h0,  16'h40, 16'h0);
        step("sw2", 1, 16'h00, 32'h40, 0, 1, 32'h8000_0016, 16'h0,  16'h40, 16'h0);
        step("sw3", 1, 16'h40, 32'h40, 1, 0, 32'h8000_0016, 16'h40, 16'h40, 16'h40);
        step("sw4", 1, 16'h00, 32'h40, 0, 0, 32'h8000_0016, 16'h0,  16'h40, 16'h40);
        step("sw5", 1, 16'h00, 32'h40, 0, 1, 32'h8000_0016, 16'h0,  16'h40, 16'h40);
        step("sw6", 1, 16'h00, 32'h40, 1, 0, 32'h8000_0016, 16'h40, 16'h0,  16'h0);
        step("sw7", 1, 16'h00, 32'h40, 0, 0, 32'h8000_0016, 16'h0,  16'h0,  16'h0);

        // Randomized traffic against the reference model.
        model_step(1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            logic        rn, irst;
            logic [15:0] req;
            logic [31:0] m;
            rn   = ($urandom_range(0, 199) != 0);
            req  = 16'($urandom & $urandom & $urandom);
            m    = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
            irst = ($urandom_range(0, 2) == 0);
            model_step(rn, req, m, irst);
            drive(rn, req, m, irst);
            check_all($sformatf("rnd%0d", c), (m_srv >= 0), m_cause, m_fin,
                      m_pend | (req & ~c_em), m_ovr);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_irq_ctrl_multi
`default_nettype wire
